// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: registers a branch request, drives the shared comparator,
// returns taken/target/trap flags over a valid/ready handshake and keeps saturating statistics.
module branch_resolve_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [2:0]       FUNC3,
  input  logic [XLEN-1:0]  RS1,
  input  logic [XLEN-1:0]  RS2,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  IMM_B,
  output logic [XLEN-1:0]  CMP_A,
  output logic [XLEN-1:0]  CMP_B,
  input  logic             CMP_EQ,
  input  logic             CMP_LT,
  input  logic             CMP_LTU,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             TAKEN,
  output logic [XLEN-1:0]  TARGET,
  output logic             ILLEGAL,
  output logic             MISALIGN,
  output logic [CNT_W-1:0] BR_COUNT,
  output logic [CNT_W-1:0] TAKEN_COUNT
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [XLEN-1:0]  FOUR    = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          state, state_nxt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic            accept, retire;
  logic            taken_nxt, illegal_nxt;
  logic [XLEN-1:0] target_nxt;

  // Comparator sees only the captured operands, so the request bus is free after the handshake.
  assign CMP_A  = rs1_q;
  assign CMP_B  = rs2_q;

  assign accept = REQ_VALID && REQ_READY && !FLUSH;
  assign retire = (state == DONE) && RES_READY && !FLUSH;

  always_comb begin
    state_nxt = state;
    if (FLUSH) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = EVAL;
        EVAL:    state_nxt = DONE;
        DONE:    if (retire) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      REQ_READY <= 1'b0;
      RES_VALID <= 1'b0;
    end else begin
      state     <= state_nxt;
      REQ_READY <= (state_nxt == IDLE);
      RES_VALID <= (state_nxt == DONE);
    end
  end

  always_comb begin
    taken_nxt   = 1'b0;
    illegal_nxt = 1'b0;
    case (f3_q)
      3'b000:  taken_nxt = CMP_EQ;
      3'b001:  taken_nxt = !CMP_EQ;
      3'b100:  taken_nxt = CMP_LT;
      3'b101:  taken_nxt = !CMP_LT;
      3'b110:  taken_nxt = CMP_LTU;
      3'b111:  taken_nxt = !CMP_LTU;
      default: illegal_nxt = 1'b1;
    endcase
    target_nxt = taken_nxt ? (pc_q + imm_q) : (pc_q + FOUR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      f3_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      TAKEN       <= 1'b0;
      TARGET      <= '0;
      ILLEGAL     <= 1'b0;
      MISALIGN    <= 1'b0;
      BR_COUNT    <= '0;
      TAKEN_COUNT <= '0;
    end else begin
      if (accept) begin
        f3_q  <= FUNC3;
        rs1_q <= RS1;
        rs2_q <= RS2;
        pc_q  <= PC;
        imm_q <= IMM_B;
      end
      if (state == EVAL && !FLUSH) begin
        TAKEN    <= taken_nxt;
        TARGET   <= target_nxt;
        ILLEGAL  <= illegal_nxt;
        MISALIGN <= taken_nxt && (target_nxt[1:0] != 2'b00);
      end
      // Statistics saturate at all-ones rather than wrapping.
      if (retire) begin
        if (!ILLEGAL && BR_COUNT != '1)  BR_COUNT    <= BR_COUNT + CNT_ONE;
        if (TAKEN && TAKEN_COUNT != '1)  TAKEN_COUNT <= TAKEN_COUNT + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; small counters so saturation is reachable quickly.
module tb_branch_resolve_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             CLK = 0, RST = 1, FLUSH = 0, REQ_VALID = 0, RES_READY = 0;
  logic [2:0]       FUNC3 = 0;
  logic [XLEN-1:0]  RS1 = 0, RS2 = 0, PC = 0, IMM_B = 0;
  logic             REQ_READY, RES_VALID, TAKEN, ILLEGAL, MISALIGN;
  logic [XLEN-1:0]  CMP_A, CMP_B, TARGET;
  logic             CMP_EQ, CMP_LT, CMP_LTU;
  logic [CNT_W-1:0] BR_COUNT, TAKEN_COUNT;

  int vectors = 0, errors = 0;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .FUNC3(FUNC3), .RS1(RS1), .RS2(RS2), .PC(PC), .IMM_B(IMM_B),
    .CMP_A(CMP_A), .CMP_B(CMP_B), .CMP_EQ(CMP_EQ), .CMP_LT(CMP_LT), .CMP_LTU(CMP_LTU),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .TAKEN(TAKEN), .TARGET(TARGET),
    .ILLEGAL(ILLEGAL), .MISALIGN(MISALIGN), .BR_COUNT(BR_COUNT), .TAKEN_COUNT(TAKEN_COUNT)
  );

  // Stand-in for the external branch condition generator.
  assign CMP_EQ  = (CMP_A == CMP_B);
  assign CMP_LT  = ($signed(CMP_A) < $signed(CMP_B));
  assign CMP_LTU = (CMP_A < CMP_B);

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  // Drives one request through the accept edge, then scrambles the request bus.
  task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm);
    @(negedge CLK);
    FUNC3 = f3; RS1 = a; RS2 = b; PC = pc; IMM_B = imm; REQ_VALID = 1;
    @(posedge CLK); #1;
    REQ_VALID = 0; FUNC3 = 3'b010; RS1 = 32'hDEAD_BEEF; RS2 = 32'h1234_5678;
    PC = 32'hABCD_0000; IMM_B = 32'h0000_0FF0;
  endtask

  task automatic test_reset;
    RST = 1; #3;
    vectors++; if (REQ_READY !== 1'b0 || RES_VALID !== 1'b0)
      begin errors++; $display("FAIL reset_hs: req_ready=%b res_valid=%b want 0 0", REQ_READY, RES_VALID); end
    vectors++; if (TARGET !== 32'h0 || TAKEN !== 1'b0 || ILLEGAL !== 1'b0 || MISALIGN !== 1'b0)
      begin errors++; $display("FAIL reset_res: target=%h taken=%b ill=%b mis=%b want 0", TARGET, TAKEN, ILLEGAL, MISALIGN); end
    vectors++; if (CMP_A !== 32'h0 || CMP_B !== 32'h0 || BR_COUNT !== 4'h0 || TAKEN_COUNT !== 4'h0)
      begin errors++; $display("FAIL reset_regs: cmp_a=%h cmp_b=%h br=%h tk=%h want 0", CMP_A, CMP_B, BR_COUNT, TAKEN_COUNT); end
    @(negedge CLK); RST = 0; #1;
    vectors++; if (REQ_READY !== 1'b0)
      begin errors++; $display("FAIL reset_release: req_ready=%b want 0 before first edge", REQ_READY); end
    @(posedge CLK); #1;
    vectors++; if (REQ_READY !== 1'b1)
      begin errors++; $display("FAIL reset_ready: req_ready=%b want 1", REQ_READY); end
  endtask

  task automatic test_beq;
    RES_READY = 1;
    accept(3'b000, 32'h5, 32'h5, 32'h100, 32'h20);
    vectors++; if (REQ_READY !== 1'b0 || RES_VALID !== 1'b0 || CMP_A !== 32'h5 || CMP_B !== 32'h5)
      begin errors++; $display("FAIL beq_eval: rdy=%b vld=%b a=%h b=%h want 0 0 5 5", REQ_READY, RES_VALID, CMP_A, CMP_B); end
    @(posedge CLK); #1;
    vectors++; if (RES_VALID !== 1'b1 || TAKEN !== 1'b1 || TARGET !== 32'h120 || ILLEGAL !== 1'b0 || MISALIGN !== 1'b0)
      begin errors++; $display("FAIL beq_res: vld=%b taken=%b target=%h ill=%b mis=%b want 1 1 120 0 0", RES_VALID, TAKEN, TARGET, ILLEGAL, MISALIGN); end
    @(posedge CLK); #1;
    vectors++; if (RES_VALID !== 1'b0 || REQ_READY !== 1'b1 || BR_COUNT !== 4'd1 || TAKEN_COUNT !== 4'd1 || TARGET !== 32'h120)
      begin errors++; $display("FAIL beq_retire: vld=%b rdy=%b br=%0d tk=%0d target=%h want 0 1 1 1 120", RES_VALID, REQ_READY, BR_COUNT, TAKEN_COUNT, TARGET); end
  endtask

  task automatic test_signed_unsigned;
    accept(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0);
    @(posedge CLK); #1;
    vectors++; if (TAKEN !== 1'b1 || TARGET !== 32'h1F0)
      begin errors++; $display("FAIL blt: taken=%b target=%h want 1 1f0", TAKEN, TARGET); end
    @(posedge CLK);
    accept(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0);
    @(posedge CLK); #1;
    vectors++; if (TAKEN !== 1'b0 || TARGET !== 32'h204 || MISALIGN !== 1'b0)
      begin errors++; $display("FAIL bltu: taken=%b target=%h mis=%b want 0 204 0", TAKEN, TARGET, MISALIGN); end
    @(posedge CLK); #1;
    vectors++; if (BR_COUNT !== 4'd3 || TAKEN_COUNT !== 4'd2)
      begin errors++; $display("FAIL signed_counts: br=%0d tk=%0d want 3 2", BR_COUNT, TAKEN_COUNT); end
  endtask

  task automatic test_illegal_misalign;
    accept(3'b010, 32'h7, 32'h7, 32'h300, 32'h40);
    @(posedge CLK); #1;
    vectors++; if (ILLEGAL !== 1'b1 || TAKEN !== 1'b0 || TARGET !== 32'h304 || MISALIGN !== 1'b0)
      begin errors++; $display("FAIL illegal: ill=%b taken=%b target=%h mis=%b want 1 0 304 0", ILLEGAL, TAKEN, TARGET, MISALIGN); end
    @(posedge CLK); #1;
    vectors++; if (BR_COUNT !== 4'd3 || TAKEN_COUNT !== 4'd2)
      begin errors++; $display("FAIL illegal_counts: br=%0d tk=%0d want 3 2", BR_COUNT, TAKEN_COUNT); end
    accept(3'b001, 32'h1, 32'h2, 32'h100, 32'h6);
    @(posedge CLK); #1;
    vectors++; if (TAKEN !== 1'b1 || TARGET !== 32'h106 || MISALIGN !== 1'b1 || ILLEGAL !== 1'b0)
      begin errors++; $display("FAIL misalign: taken=%b target=%h mis=%b ill=%b want 1 106 1 0", TAKEN, TARGET, MISALIGN, ILLEGAL); end
    @(posedge CLK); #1;
    vectors++; if (BR_COUNT !== 4'd4 || TAKEN_COUNT !== 4'd3)
      begin errors++; $display("FAIL misalign_counts: br=%0d tk=%0d want 4 3", BR_COUNT, TAKEN_COUNT); end
  endtask

  task automatic test_backpressure_wrap;
    RES_READY = 0;
    accept(3'b000, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h8);
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      vectors++; if (RES_VALID !== 1'b1 || REQ_READY !== 1'b0 || TAKEN !== 1'b0 || TARGET !== 32'h0)
        begin errors++; $display("FAIL stall_%0d: vld=%b rdy=%b taken=%b target=%h want 1 0 0 0", i, RES_VALID, REQ_READY, TAKEN, TARGET); end
    end
    vectors++; if (BR_COUNT !== 4'd4)
      begin errors++; $display("FAIL stall_counts: br=%0d want 4", BR_COUNT); end
    RES_READY = 1;
    @(posedge CLK); #1;
    vectors++; if (RES_VALID !== 1'b0 || REQ_READY !== 1'b1 || BR_COUNT !== 4'd5 || TAKEN_COUNT !== 4'd3)
      begin errors++; $display("FAIL stall_retire: vld=%b rdy=%b br=%0d tk=%0d want 0 1 5 3", RES_VALID, REQ_READY, BR_COUNT, TAKEN_COUNT); end
  endtask

  task automatic test_flush;
    // Flush while in EVAL.
    accept(3'b000, 32'h9, 32'h9, 32'h400, 32'h10);
    FLUSH = 1;
    @(posedge CLK); #1; FLUSH = 0;
    vectors++; if (RES_VALID !== 1'b0 || REQ_READY !== 1'b1 || TARGET !== 32'h0)
      begin errors++; $display("FAIL flush_eval: vld=%b rdy=%b target=%h want 0 1 0", RES_VALID, REQ_READY, TARGET); end
    // Flush in DONE with the consumer ready: no retire.
    accept(3'b000, 32'h11, 32'h11, 32'h500, 32'h10);
    @(posedge CLK); #1;
    FLUSH = 1;
    @(posedge CLK); #1; FLUSH = 0;
    vectors++; if (RES_VALID !== 1'b0 || REQ_READY !== 1'b1 || BR_COUNT !== 4'd5 || TAKEN_COUNT !== 4'd3)
      begin errors++; $display("FAIL flush_done: vld=%b rdy=%b br=%0d tk=%0d want 0 1 5 3", RES_VALID, REQ_READY, BR_COUNT, TAKEN_COUNT); end
    // Flush with a concurrent request in IDLE.
    @(negedge CLK);
    FUNC3 = 3'b000; RS1 = 32'hAA; RS2 = 32'hAA; REQ_VALID = 1; FLUSH = 1;
    @(posedge CLK); #1; REQ_VALID = 0; FLUSH = 0;
    vectors++; if (REQ_READY !== 1'b1 || CMP_A !== 32'h11 || RES_VALID !== 1'b0)
      begin errors++; $display("FAIL flush_idle: rdy=%b cmp_a=%h vld=%b want 1 11 0", REQ_READY, CMP_A, RES_VALID); end
    @(posedge CLK); #1;
    vectors++; if (RES_VALID !== 1'b0 || REQ_READY !== 1'b1)
      begin errors++; $display("FAIL flush_idle_hold: vld=%b rdy=%b want 0 1", RES_VALID, REQ_READY); end
  endtask

  task automatic test_saturation;
    // br goes 5->15 after 10, tk 3->15 after 12; run 14 to push both past the top.
    for (int i = 0; i < 14; i++) begin
      accept(3'b000, 32'h3, 32'h3, 32'h600, 32'h40);
      @(posedge CLK); @(posedge CLK); #1;
    end
    vectors++; if (BR_COUNT !== 4'hF || TAKEN_COUNT !== 4'hF)
      begin errors++; $display("FAIL saturate: br=%h tk=%h want f f", BR_COUNT, TAKEN_COUNT); end
    accept(3'b101, 32'h8, 32'h3, 32'h600, 32'h40);
    @(posedge CLK); #1;
    vectors++; if (TAKEN !== 1'b1 || TARGET !== 32'h640)
      begin errors++; $display("FAIL bge: taken=%b target=%h want 1 640", TAKEN, TARGET); end
    @(posedge CLK); #1;
    vectors++; if (BR_COUNT !== 4'hF || TAKEN_COUNT !== 4'hF)
      begin errors++; $display("FAIL saturate_hold: br=%h tk=%h want f f", BR_COUNT, TAKEN_COUNT); end
  endtask

  task automatic test_reset_mid;
    accept(3'b111, 32'h1, 32'h2, 32'h700, 32'h20);
    #2 RST = 1; #1;
    vectors++; if (REQ_READY !== 1'b0 || RES_VALID !== 1'b0 || TARGET !== 32'h0 || TAKEN !== 1'b0)
      begin errors++; $display("FAIL rst_mid_out: rdy=%b vld=%b target=%h taken=%b want 0", REQ_READY, RES_VALID, TARGET, TAKEN); end
    vectors++; if (CMP_A !== 32'h0 || BR_COUNT !== 4'h0 || TAKEN_COUNT !== 4'h0)
      begin errors++; $display("FAIL rst_mid_regs: cmp_a=%h br=%h tk=%h want 0", CMP_A, BR_COUNT, TAKEN_COUNT); end
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
    vectors++; if (REQ_READY !== 1'b1 || RES_VALID !== 1'b0)
      begin errors++; $display("FAIL rst_mid_release: rdy=%b vld=%b want 1 0", REQ_READY, RES_VALID); end
  endtask

  initial begin
    test_reset;
    test_beq;
    test_signed_unsigned;
    test_illegal_misalign;
    test_backpressure_wrap;
    test_flush;
    test_saturation;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
